// File: rtl/serial_rx_frame.sv
// serial_rx_frame: LSB-first serial frame receiver (start, N data bits,
// optional even parity, stop) with an enable qualifier on every bit.
module serial_rx_frame #(
  parameter int N         = 4,
  parameter int PARITY_EN = 1
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         En,
  input  logic         Sin,
  output logic [N-1:0] Dout,
  output logic         Valid,
  output logic         PErr,
  output logic         FErr,
  output logic         Busy,
  output logic [7:0]   FrameCnt
);

  localparam int CW = $clog2(N);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_bitcnt;
  logic [N-1:0]  r_shift;
  logic          r_perr_pend;
  logic [N-1:0]  r_dout;
  logic          r_valid;
  logic          r_perr;
  logic          r_ferr;
  logic          r_busy;
  logic [7:0]    r_framecnt;

  logic          w_last_bit;
  logic          w_par_err;

  assign w_last_bit = (r_bitcnt == CW'(N - 1));
  // Even parity: all data bits XOR the parity bit must come out zero.
  assign w_par_err  = (^r_shift) ^ Sin;

  // Frame FSM, shift register and registered status outputs.
  // Data bits enter at the MSB and shift down, so after N bits the first
  // received bit sits in bit 0, i.e. bit k lands at index k.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_perr_pend <= 1'b0;
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_busy      <= 1'b0;
      r_framecnt  <= 8'd0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (En) begin
        case (r_state)
          S_IDLE: begin
            if (!Sin) begin
              r_state     <= S_DATA;
              r_bitcnt    <= '0;
              r_perr_pend <= 1'b0;
              r_busy      <= 1'b1;
            end
          end
          S_DATA: begin
            r_shift  <= {Sin, r_shift[N-1:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (w_last_bit) begin
              r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
          end
          S_PARITY: begin
            r_perr_pend <= w_par_err;
            r_state     <= S_STOP;
          end
          default: begin
            // Stop bit: good stop publishes the word, bad stop only flags.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (Sin) begin
              r_dout  <= r_shift;
              r_valid <= 1'b1;
              r_perr  <= r_perr_pend;
              if (!r_perr_pend) begin
                r_framecnt <= r_framecnt + 8'd1;
              end
            end else begin
              r_ferr <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign Dout     = r_dout;
  assign Valid    = r_valid;
  assign PErr     = r_perr;
  assign FErr     = r_ferr;
  assign Busy     = r_busy;
  assign FrameCnt = r_framecnt;

endmodule

// File: tb/tb_serial_rx_frame.sv
// tb_serial_rx_frame: random and directed frames, scoreboard-checked.
module tb_serial_rx_frame;

  localparam int N         = 4;
  localparam int PARITY_EN = 1;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         En    = 1'b0;
  logic         Sin   = 1'b1;
  logic [N-1:0] Dout;
  logic         Valid;
  logic         PErr;
  logic         FErr;
  logic         Busy;
  logic [7:0]   FrameCnt;

  serial_rx_frame #(.N(N), .PARITY_EN(PARITY_EN)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .En       (En),
    .Sin      (Sin),
    .Dout     (Dout),
    .Valid    (Valid),
    .PErr     (PErr),
    .FErr     (FErr),
    .Busy     (Busy),
    .FrameCnt (FrameCnt)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit           ferr;
    logic [N-1:0] dout;
    bit           perr;
    logic [7:0]   cnt;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           ecnt   = 0;
  int           n_chk  = 0;
  int           n_pass = 0;
  int           n_valid = 0;

  // Reference state: what the outputs should hold after all frames so far.
  logic [N-1:0] m_dout = '0;
  bit           m_perr = 1'b0;
  logic [7:0]   m_cnt  = 8'd0;

  always @(posedge Clock) ecnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input bit en, input bit s);
    En  = en;
    Sin = s;
    @(posedge Clock);
    #1;
  endtask

  task automatic send_bit(input bit b, input int gaps);
    drive(1'b1, b);
    for (int g = 0; g < gaps; g++) drive(1'b0, 1'($urandom % 2));
  endtask

  task automatic model_reset();
    m_dout = '0;
    m_perr = 1'b0;
    m_cnt  = 8'd0;
  endtask

  // Sends one frame; par_flip inverts the correct even-parity bit.
  task automatic send_frame(input logic [N-1:0] data, input bit par_flip,
                            input bit stop, input int gaps);
    exp_t e;
    bit   perr;
    send_bit(1'b0, gaps);
    for (int i = 0; i < N; i++) send_bit(data[i], gaps);
    perr = 1'b0;
    if (PARITY_EN != 0) begin
      send_bit((^data) ^ par_flip, gaps);
      perr = par_flip;
    end
    if (stop) begin
      m_dout = data;
      m_perr = perr;
      if (!perr) m_cnt = m_cnt + 8'd1;
    end
    e.ferr = !stop;
    e.dout = m_dout;
    e.perr = m_perr;
    e.cnt  = m_cnt;
    e.due  = ecnt + 1;
    sb.push_back(e);
    send_bit(stop, gaps);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dout"},  32'(Dout),     32'd0);
    chk({tag, "_valid"}, 32'(Valid),    32'd0);
    chk({tag, "_perr"},  32'(PErr),     32'd0);
    chk({tag, "_ferr"},  32'(FErr),     32'd0);
    chk({tag, "_busy"},  32'(Busy),     32'd0);
    chk({tag, "_cnt"},   32'(FrameCnt), 32'd0);
  endtask

  // Monitor: pops one expectation per Valid/FErr pulse.
  bit prev_valid = 1'b0;
  bit prev_ferr  = 1'b0;
  always @(negedge Clock) begin
    if (Valid && FErr) chk("valid_and_ferr", 32'd1, 32'd0);
    if (Valid && prev_valid) chk("valid_width", 32'd2, 32'd1);
    if (FErr && prev_ferr) chk("ferr_width", 32'd2, 32'd1);
    prev_valid = Valid;
    prev_ferr  = FErr;
    if (Valid || FErr) begin
      if (Valid) n_valid++;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, Valid, FErr}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("kind_ferr", 32'(FErr),     32'(e.ferr));
        chk("latency",   32'(ecnt),     32'(e.due));
        chk("dout",      32'(Dout),     32'(e.dout));
        chk("perr",      32'(PErr),     32'(e.perr));
        chk("framecnt",  32'(FrameCnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    int v0;
    // Reset state
    Reset = 1'b1;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    check_all_zero("reset");
    Reset = 1'b0;
    drive(1'b0, 1'b1);

    // Good frame 4'hD, then idle
    send_frame(4'hD, 1'b0, 1'b1, 0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    chk("busy_idle", 32'(Busy), 32'd0);
    chk("cnt_after_good", 32'(FrameCnt), 32'd1);

    // Parity error
    send_frame(4'hD, 1'b1, 1'b1, 0);
    // Framing error
    send_frame(4'h3, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b1);
    chk("dout_after_ferr", 32'(Dout), 32'hD);
    // En gaps with random Sin
    send_frame(4'hD, 1'b0, 1'b1, 3);

    // Reset mid-frame
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    chk("busy_mid", 32'(Busy), 32'd1);
    Reset = 1'b1;
    drive(1'b1, 1'b0);
    Reset = 1'b0;
    model_reset();
    check_all_zero("mid_reset");
    send_frame(4'h6, 1'b0, 1'b1, 0);
    drive(1'b1, 1'b1);

    // Random frames
    for (int k = 0; k < 60; k++) begin
      send_frame(N'($urandom), ($urandom % 5) == 0, ($urandom % 6) != 0,
                 int'($urandom % 3));
      if ($urandom % 3 == 0) drive(1'b1, 1'b1);
    end

    // 256 back-to-back good frames from reset
    Reset = 1'b1;
    drive(1'b0, 1'b1);
    Reset = 1'b0;
    model_reset();
    v0 = n_valid;
    for (int k = 0; k < 256; k++) send_frame(N'($urandom), 1'b0, 1'b1, 0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    chk("b2b_valid_count", 32'(n_valid - v0), 32'd256);
    chk("b2b_wrap_cnt", 32'(FrameCnt), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
